// File: rtl/mdu_pkg.sv
// Shared op codes and FSM encoding for the iterative multiply/divide unit.
package mdu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t MDU_MULT  = 3'd0;
    localparam op_t MDU_MULTU = 3'd1;
    localparam op_t MDU_DIV   = 3'd2;
    localparam op_t MDU_DIVU  = 3'd3;
    localparam op_t MDU_MTHI  = 3'd4;
    localparam op_t MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    import mdu_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift the dividend MSB into the
// partial remainder, trial-subtract the divisor, shift in the quotient bit.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    // rem_i < dvs_i keeps diff within WIDTH+1 bits, so its MSB is the borrow.
    always_comb begin
        part = {rem_i, quo_i[WIDTH-1]};
        diff = part - {1'b0, dvs_i};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = part[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO,
// a start/busy/done handshake and a flush that aborts the in-flight op.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    mdu_iter_if.slave  bus
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_DIV = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   ma_q, ma_d, mb_q, mb_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] step_rem, step_quo;

    function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] x);
        return c ? -x : x;
    endfunction

    // Multiplier on sign/zero-extended operands; product retimed through MUL_LAT-1 stages.
    logic signed [2*WIDTH+1:0] ma_x, mb_x, mul_full;
    logic [2*WIDTH-1:0]        mul_prod;
    logic [1:0]                unused_mul_msb;

    assign ma_x           = {{(WIDTH+1){ma_q[WIDTH]}}, ma_q};
    assign mb_x           = {{(WIDTH+1){mb_q[WIDTH]}}, mb_q};
    assign mul_full       = ma_x * mb_x;
    assign unused_mul_msb = mul_full[2*WIDTH+1:2*WIDTH];

    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign mul_prod = mul_full[2*WIDTH-1:0];
        end else begin : g_mul_pipe
            logic [MUL_LAT-2:0][2*WIDTH-1:0] mul_pipe_q;
            always_ff @(posedge clk) begin
                mul_pipe_q[0] <= mul_full[2*WIDTH-1:0];
                for (int i = 1; i < MUL_LAT - 1; i++)
                    mul_pipe_q[i] <= mul_pipe_q[i-1];
            end
            assign mul_prod = mul_pipe_q[MUL_LAT-2];
        end
    endgenerate

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        ma_d    = ma_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        sgn     = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_neg   = sgn & bus.a[WIDTH-1];
        b_neg   = sgn & bus.b[WIDTH-1];

        // Flush drops any in-flight op and any start presented with it.
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    case (bus.op)
                        MDU_MULT, MDU_MULTU: begin
                            ma_d    = {a_neg, bus.a};
                            mb_d    = {b_neg, bus.b};
                            cnt_d   = CNT_MUL;
                            state_d = S_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            rem_d  = '0;
                            dvs_d  = neg_if(b_neg, bus.b);
                            qneg_d = a_neg ^ b_neg;
                            rneg_d = a_neg;
                            if (bus.b == '0) begin
                                // Raw dividend parked in quo for the hi=a writeback.
                                dz_d    = 1'b1;
                                quo_d   = bus.a;
                                state_d = S_FIX;
                            end else begin
                                dz_d    = 1'b0;
                                quo_d   = neg_if(a_neg, bus.a);
                                cnt_d   = CNT_DIV;
                                state_d = S_DIV;
                            end
                        end
                        MDU_MTHI: hi_d = bus.a;
                        MDU_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = mul_prod;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = quo_q;
                    end else begin
                        lo_d = neg_if(qneg_q, quo_q);
                        hi_d = neg_if(rneg_q, rem_q);
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed + randomised bench for mdu_iter; a queue of reference {hi,lo}
// results is popped and compared on every done pulse.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus();

    mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_cmp = 0;
    int              n_err = 0;
    logic [2*W-1:0]  exp_q[$];
    logic [2*W-1:0]  mon_e;
    logic [W-1:0]    mhi, mlo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'd0;
        case (op)
            MDU_MULT:  res = 64'(sa * sb);
            MDU_MULTU: res = {32'd0, a} * {32'd0, b};
            MDU_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MDU_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            check("done_busy", {63'd0, bus.busy}, 64'd0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {bus.hi, bus.lo}, mon_e);
            end
        end
    end

    task automatic issue(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        logic [63:0] r;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            r = model(op, a, b);
            exp_q.push_back(r);
            {mhi, mlo} = r;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called in cycle T+1; returns the cycle offset (relative to T) of done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", {63'd0, bus.done}, 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, k, inj, blen, explat;
        op_t rop;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = MDU_MULT; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        mhi = '0; mlo = '0;
        repeat (2) @(negedge clk);
        check("rst_hi",   64'(bus.hi), 64'd0);
        check("rst_lo",   64'(bus.lo), 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;

        issue(MDU_MTHI, 32'h1234, '0, 1'b0);
        mhi = 32'h1234;
        check("mthi_hi",   64'(bus.hi), 64'h1234);
        check("mthi_done", {63'd0, bus.done}, 64'd0);
        check("mthi_busy", {63'd0, bus.busy}, 64'd0);
        issue(MDU_MTLO, 32'h5678, '0, 1'b0);
        mlo = 32'h5678;
        check("mtlo_lo", 64'(bus.lo), 64'h5678);

        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done(c);
        check("mult_lat", 64'(c), 64'(ML + 1));
        check("mult_val", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_done(c);
        check("multu_val", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

        issue(MDU_DIV, -32'sd7, 32'd2, 1'b1);
        wait_done(c);
        check("div_lat", 64'(c), 64'(W + 2));
        check("div_val", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_DIVU, 32'd7, 32'd2, 1'b1);
        wait_done(c);
        check("divu_val", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(c);
        check("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        issue(MDU_DIVU, 32'd5, 32'd0, 1'b1);
        wait_done(c);
        check("dz_lat", 64'(c), 64'd2);
        check("dz_val", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);

        // Flush at T+10 of a divide.
        issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, {mhi, mlo});
        repeat (40) @(negedge clk);
        check("flush_nodone", {63'd0, bus.done}, 64'd0);

        // Flush beats a simultaneous MTHI.
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MTHI; bus.a = 32'hDEAD; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_mthi", 64'(bus.hi), 64'(mhi));

        // Start held through busy is taken once, in the done cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd1000; bus.b = 32'd1000;
        exp_q.push_back(model(MDU_MULTU, 32'd1000, 32'd1000));
        @(negedge clk);
        bus.op = MDU_DIVU; bus.a = 32'd1000; bus.b = 32'd33;
        exp_q.push_back(model(MDU_DIVU, 32'd1000, 32'd33));
        {mhi, mlo} = model(MDU_DIVU, 32'd1000, 32'd33);
        wait_done(c);
        check("held_lat1", 64'(c), 64'(ML + 1));
        @(negedge clk);
        bus.start = 1'b0;
        check("held_busy", {63'd0, bus.busy}, 64'd1);
        wait_done(c);
        check("held_lat2", 64'(c), 64'(W + 2));
        repeat (5) @(negedge clk);

        // Flush in the done cycle leaves the committed result.
        issue(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done(c);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_done", {bus.hi, bus.lo}, {mhi, mlo});

        for (int it = 0; it < 40; it++) begin
            rop = op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = '1; end
            inj    = $urandom_range(0, 3);
            blen   = (rop < MDU_DIV) ? ML : ((rb == 0) ? 1 : W + 1);
            explat = blen + 1;
            if (inj >= 2) begin
                issue(rop, ra, rb, 1'b1);
                wait_done(c);
                check("rand_lat", 64'(c), 64'(explat));
            end else begin
                k = $urandom_range(1, blen);
                issue(rop, ra, rb, 1'b0);
                repeat (k - 1) @(negedge clk);
                if (inj == 0) bus.flush = 1'b1;
                else          rst = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
                if (rst) begin mhi = '0; mlo = '0; end
                rst = 1'b0;
                check("rand_inj_busy", {63'd0, bus.busy}, 64'd0);
                check("rand_inj_hilo", {bus.hi, bus.lo}, {mhi, mlo});
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
